// File: rtl/stage_wb.sv
// rtl/stage_wb.sv - MEM/WB pipeline register with load extraction, misalignment check and retire counter
module stage_wb (
   input  logic        clock,
   input  logic        reset,
   input  logic        ex_mem_valid,
   input  logic        ex_mem_regwrite,
   input  logic        ex_mem_memtoreg,
   input  logic        ex_mem_memread,
   input  logic [2:0]  ex_mem_funct3,
   input  logic [4:0]  ex_mem_rd,
   input  logic [31:0] ex_mem_alu_result,
   input  logic [31:0] mem_read_data,
   input  logic        wb_stall,
   input  logic        wb_flush,
   output logic        wb_valid,
   output logic        wb_regwrite,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_write_data,
   output logic        wb_misaligned,
   output logic [63:0] wb_instret
);

   logic [1:0]  addr_lo;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;
   logic [31:0] data_d;
   logic        misaligned_d;
   logic        regwrite_d;
   logic        retire_d;

   logic        valid_q;
   logic        regwrite_q;
   logic        misaligned_q;
   logic [4:0]  rd_q;
   logic [31:0] data_q;
   logic [63:0] instret_q;

   assign addr_lo = ex_mem_alu_result[1:0];

   // Misaligned loads still return data; the low offset bits are simply ignored by the lane select.
   always_comb begin
      byte_sel = mem_read_data[7:0];
      case (addr_lo)
         2'd0:    byte_sel = mem_read_data[7:0];
         2'd1:    byte_sel = mem_read_data[15:8];
         2'd2:    byte_sel = mem_read_data[23:16];
         default: byte_sel = mem_read_data[31:24];
      endcase
      half_sel = addr_lo[1] ? mem_read_data[31:16] : mem_read_data[15:0];
      load_data = mem_read_data;
      case (ex_mem_funct3)
         3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_data = {24'h000000, byte_sel};
         3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_data = {16'h0000, half_sel};
         default: load_data = mem_read_data;
      endcase
   end

   // funct3[1]=1 selects the word class, funct3[1:0]=01 the halfword loads.
   assign misaligned_d = ex_mem_memread &&
                         (((ex_mem_funct3[1:0] == 2'b01) && addr_lo[0]) ||
                          (ex_mem_funct3[1] && (addr_lo != 2'b00)));
   assign data_d       = ex_mem_memtoreg ? load_data : ex_mem_alu_result;
   assign regwrite_d   = ex_mem_regwrite && ex_mem_valid && (ex_mem_rd != 5'd0) && !misaligned_d;
   assign retire_d     = ex_mem_valid && !misaligned_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q      <= 1'b0;
         regwrite_q   <= 1'b0;
         misaligned_q <= 1'b0;
         rd_q         <= 5'd0;
         data_q       <= 32'd0;
         instret_q    <= 64'd0;
      end else if (wb_flush) begin
         valid_q      <= 1'b0;
         regwrite_q   <= 1'b0;
         misaligned_q <= 1'b0;
         rd_q         <= 5'd0;
         data_q       <= 32'd0;
      end else if (!wb_stall) begin
         valid_q      <= ex_mem_valid;
         regwrite_q   <= regwrite_d;
         misaligned_q <= misaligned_d;
         rd_q         <= ex_mem_rd;
         data_q       <= data_d;
         if (retire_d) begin
            instret_q <= instret_q + 64'd1;
         end
      end
   end

   assign wb_valid      = valid_q;
   assign wb_regwrite   = regwrite_q;
   assign wb_misaligned = misaligned_q;
   assign wb_rd         = rd_q;
   assign wb_write_data = data_q;
   assign wb_instret    = instret_q;

endmodule

// File: tb/tb_stage_wb.sv
// tb/tb_stage_wb.sv - directed vector table and corner-case sequences for stage_wb
module tb_stage_wb;

   logic        clock = 1'b0;
   logic        reset;
   logic        ex_mem_valid, ex_mem_regwrite, ex_mem_memtoreg, ex_mem_memread;
   logic [2:0]  ex_mem_funct3;
   logic [4:0]  ex_mem_rd;
   logic [31:0] ex_mem_alu_result, mem_read_data;
   logic        wb_stall, wb_flush;
   logic        wb_valid, wb_regwrite, wb_misaligned;
   logic [4:0]  wb_rd;
   logic [31:0] wb_write_data;
   logic [63:0] wb_instret;

   int n_vec = 0;
   int n_bad = 0;
   logic [63:0] exp_instret;

   stage_wb dut (
      .clock(clock), .reset(reset),
      .ex_mem_valid(ex_mem_valid), .ex_mem_regwrite(ex_mem_regwrite),
      .ex_mem_memtoreg(ex_mem_memtoreg), .ex_mem_memread(ex_mem_memread),
      .ex_mem_funct3(ex_mem_funct3), .ex_mem_rd(ex_mem_rd),
      .ex_mem_alu_result(ex_mem_alu_result), .mem_read_data(mem_read_data),
      .wb_stall(wb_stall), .wb_flush(wb_flush),
      .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
      .wb_write_data(wb_write_data), .wb_misaligned(wb_misaligned),
      .wb_instret(wb_instret)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        v, rw, m2r, mr;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] alu, mem;
      logic        e_v, e_rw;
      logic [31:0] e_data;
      logic        e_mis, inc;
   } vec_t;

   vec_t tbl [14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic v, input logic rw, input logic [4:0] rd,
                            input logic [31:0] data, input logic mis, input logic [63:0] ir);
      check({tag, ".valid"},      {63'd0, wb_valid},      {63'd0, v});
      check({tag, ".regwrite"},   {63'd0, wb_regwrite},   {63'd0, rw});
      check({tag, ".rd"},         {59'd0, wb_rd},         {59'd0, rd});
      check({tag, ".data"},       {32'd0, wb_write_data}, {32'd0, data});
      check({tag, ".misaligned"}, {63'd0, wb_misaligned}, {63'd0, mis});
      check({tag, ".instret"},    wb_instret,             ir);
   endtask

   task automatic drive(input logic v, input logic rw, input logic m2r, input logic mr,
                        input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] mem);
      ex_mem_valid = v; ex_mem_regwrite = rw; ex_mem_memtoreg = m2r; ex_mem_memread = mr;
      ex_mem_funct3 = f3; ex_mem_rd = rd; ex_mem_alu_result = alu; mem_read_data = mem;
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   initial begin
      //         v     rw    m2r   mr    f3      rd     alu            mem             e_v   e_rw  e_data         e_mis inc
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 5'd5,  32'h0000_1003, 32'h80FF_1234, 1'b1, 1'b1, 32'hFFFF_FF80, 1'b0, 1'b1};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b101, 5'd6,  32'h0000_1002, 32'h8001_7FFF, 1'b1, 1'b1, 32'h0000_8001, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b001, 5'd6,  32'h0000_1002, 32'h8001_7FFF, 1'b1, 1'b1, 32'hFFFF_8001, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 5'd7,  32'h0000_1006, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 5'd0,  32'h0000_0005, 32'h1111_1111, 1'b1, 1'b0, 32'h0000_0005, 1'b0, 1'b1};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b100, 5'd7,  32'h0000_1001, 32'h80FF_1234, 1'b1, 1'b1, 32'h0000_0012, 1'b0, 1'b1};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b000, 5'd8,  32'h0000_1000, 32'h0000_00F0, 1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b001, 5'd9,  32'h0000_1001, 32'h1234_ABCD, 1'b1, 1'b0, 32'hFFFF_ABCD, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 5'd3,  32'h0000_0007, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 5'd31, 32'h0000_2000, 32'hCAFE_F00D, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0, 1'b1};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b111, 5'd4,  32'h0000_2004, 32'h0102_0304, 1'b1, 1'b1, 32'h0102_0304, 1'b0, 1'b1};
      tbl[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b010, 5'd10, 32'h0000_1006, 32'h5566_7788, 1'b1, 1'b1, 32'h5566_7788, 1'b0, 1'b1};
      tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 5'd9,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b1};
      tbl[13] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'b100, 5'd2,  32'h0000_1003, 32'hA5FF_0000, 1'b1, 1'b1, 32'h0000_00A5, 1'b0, 1'b1};

      reset = 1'b1; wb_stall = 1'b0; wb_flush = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'd0, 32'd0);
      repeat (2) @(posedge clock);
      #1;
      exp_instret = 64'd0;
      check_all("reset", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, exp_instret);

      @(negedge clock);
      reset = 1'b0;
      for (int i = 0; i < 14; i++) begin
         drive(tbl[i].v, tbl[i].rw, tbl[i].m2r, tbl[i].mr, tbl[i].f3, tbl[i].rd, tbl[i].alu, tbl[i].mem);
         step();
         if (tbl[i].inc) exp_instret = exp_instret + 64'd1;
         check_all($sformatf("vec%0d", i), tbl[i].e_v, tbl[i].e_rw, tbl[i].rd, tbl[i].e_data,
                   tbl[i].e_mis, exp_instret);
         @(negedge clock);
      end

      // Stall for three cycles with changing inputs: everything frozen.
      drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 5'd12, 32'h0000_ABCD, 32'd0);
      step();
      exp_instret = exp_instret + 64'd1;
      check_all("pre_stall", 1'b1, 1'b1, 5'd12, 32'h0000_ABCD, 1'b0, exp_instret);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         wb_stall = 1'b1;
         drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 5'(13 + k), 32'(100 + k), 32'd0);
         step();
         check_all($sformatf("stall%0d", k), 1'b1, 1'b1, 5'd12, 32'h0000_ABCD, 1'b0, exp_instret);
      end

      // Stall and flush together act as flush.
      @(negedge clock);
      wb_flush = 1'b1;
      step();
      check_all("stall_flush", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, exp_instret);

      // Flush alone clears a captured misaligned flag without retiring.
      @(negedge clock);
      wb_stall = 1'b0; wb_flush = 1'b0;
      drive(1'b1, 1'b1, 1'b1, 1'b1, 3'b010, 5'd5, 32'h0000_3002, 32'h0BAD_F00D);
      step();
      check_all("mis_before_flush", 1'b1, 1'b0, 5'd5, 32'h0BAD_F00D, 1'b1, exp_instret);
      @(negedge clock);
      wb_flush = 1'b1;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 5'd6, 32'h0000_0001, 32'd0);
      step();
      check_all("flush", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, exp_instret);

      // Counter wrap from all ones.
      @(negedge clock);
      wb_flush = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 5'd1, 32'h0000_0042, 32'd0);
      force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.instret_q;
      step();
      exp_instret = 64'd0;
      check_all("wrap", 1'b1, 1'b1, 5'd1, 32'h0000_0042, 1'b0, exp_instret);

      // Reset asserted mid-cycle clears outputs before the next edge.
      @(negedge clock);
      drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 5'd2, 32'h0000_0077, 32'd0);
      step();
      exp_instret = exp_instret + 64'd1;
      check_all("pre_reset", 1'b1, 1'b1, 5'd2, 32'h0000_0077, 1'b0, exp_instret);
      #2;
      reset = 1'b1;
      #1;
      exp_instret = 64'd0;
      check_all("async_reset", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, exp_instret);

      // Reset during a stall discards held state; first capture after release starts from zero.
      @(negedge clock);
      reset = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 5'd3, 32'h0000_0099, 32'd0);
      step();
      exp_instret = 64'd1;
      check_all("post_reset", 1'b1, 1'b1, 5'd3, 32'h0000_0099, 1'b0, exp_instret);
      @(negedge clock);
      wb_stall = 1'b1;
      step();
      #2;
      reset = 1'b1;
      #1;
      exp_instret = 64'd0;
      check_all("reset_in_stall", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, exp_instret);
      @(negedge clock);
      reset = 1'b0;
      step();
      check_all("stall_after_reset", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, exp_instret);
      @(negedge clock);
      wb_stall = 1'b0;
      step();
      exp_instret = 64'd1;
      check_all("resume", 1'b1, 1'b1, 5'd3, 32'h0000_0099, 1'b0, exp_instret);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
